// File: rtl/rs_pkg.sv
// Shared definitions for the rs_* serial blocks: receiver/transmitter state
// encoding and the bit-rate divider derived from the system clock.
package rs_pkg;

    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 115200;
    // Clock cycles per serial bit (rounded down; 434 for 50 MHz / 115200).
    localparam int DIVIDER = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rs_state_t;

endpackage

// File: rtl/rs_rx_if.sv
// Consumer-side bundle of the UART receiver: serial line in, byte buffer
// with level-valid / acknowledge handshake and status pulses out.
interface rs_rx_if;
    logic       rx;
    logic       rd_ack;
    logic [7:0] data;
    logic       dataready;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    // Receiver side
    modport slave (
        input  rx,
        input  rd_ack,
        output data,
        output dataready,
        output framing_err,
        output overrun,
        output busy
    );

    // Line driver / consumer side
    modport master (
        output rx,
        output rd_ack,
        input  data,
        input  dataready,
        input  framing_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/rs_sync2.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look active while in reset.
module rs_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    // Shift the async input through two flops to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/rs_rx.sv
// 8N1 UART receiver. Validates the start bit at mid-bit, samples data bits
// LSB-first at mid-bit, checks the stop bit and hands good bytes to a
// one-entry buffer with a dataready / rd_ack handshake.
module rs_rx #(
    parameter int DIVIDER = rs_pkg::DIVIDER
) (
    input  logic     clk,
    input  logic     rst,
    rs_rx_if.slave   bus
);
    import rs_pkg::*;

    localparam int TW = $clog2(DIVIDER);
    // Start bit is re-checked half a bit after the edge; every later sample
    // is one full bit period after the previous one, so it lands mid-bit.
    localparam logic [TW-1:0] HALF_TICK = TW'(DIVIDER / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(DIVIDER - 1);

    logic            rxs;
    rs_state_t       state_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      shift_reg;
    logic [7:0]      data_reg;
    logic            dataready_reg;
    logic            framing_err_reg;
    logic            overrun_reg;
    logic            busy_reg;

    // Line is idle-high, so hold the synchronised copy high during reset.
    rs_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rxs)
    );

    // Frame FSM, bit timing counters, shift register and output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            tick_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            data_reg        <= '0;
            dataready_reg   <= 1'b0;
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            // Consumer takes the byte; a same-cycle load below overrides this.
            if (bus.rd_ack && dataready_reg) begin
                dataready_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (!rxs) begin
                        tick_cnt_reg <= '0;
                        state_reg    <= START;
                        busy_reg     <= 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt_reg == HALF_TICK) begin
                        if (!rxs) begin
                            tick_cnt_reg <= '0;
                            bit_cnt_reg  <= '0;
                            state_reg    <= DATA;
                        end else begin
                            // Line went back high: glitch, not a start bit.
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_reg == FULL_TICK) begin
                        shift_reg    <= {rxs, shift_reg[7:1]};
                        tick_cnt_reg <= '0;
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_reg == FULL_TICK) begin
                        tick_cnt_reg <= '0;
                        if (rxs) begin
                            if (!dataready_reg || bus.rd_ack) begin
                                data_reg      <= shift_reg;
                                dataready_reg <= 1'b1;
                            end else begin
                                overrun_reg <= 1'b1;
                            end
                            // Leaving at mid-stop gives half a bit of slack
                            // for the next start edge.
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            framing_err_reg <= 1'b1;
                            state_reg       <= BREAK;
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                BREAK: begin
                    // Held-low line must not be taken as repeated start bits.
                    if (rxs) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data        = data_reg;
    assign bus.dataready   = dataready_reg;
    assign bus.framing_err = framing_err_reg;
    assign bus.overrun     = overrun_reg;
    assign bus.busy        = busy_reg;
endmodule
